// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the RAM-port controller: access lengths, FSM states,
// I/O region marker and the length-to-byte-count helper.
package mem_ctrl_pkg;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b11;

  // addr[17:16] value that selects the memory-mapped I/O region
  localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    STORE = 2'd3
  } state_t;

  // Number of RAM byte accesses for a load/store length code
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: sole owner of the 8-bit RAM port. Arbitrates between instruction
// fetches and load/store requests, serialises each into per-byte accesses and
// assembles read bytes little-endian into a 32-bit result.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_HI = IO_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata
);

  state_t      state;
  logic [2:0]  k;        // reads step 0..N: the extra step drains the last RAM byte
  logic [2:0]  nbytes;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] acc;
  logic [31:0] acc_nx;
  logic [1:0]  cap_idx;
  logic        reading;
  logic        io_stall;

  // Activity decode and accumulator with the incoming byte merged in
  always_comb begin
    reading  = (state == FETCH) || (state == LOAD);
    io_stall = (state == STORE) && io_buffer_full && (addr[17:16] == IO_HI);
    cap_idx  = k[1:0] - 2'd1;
    acc_nx   = acc;
    acc_nx[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  // RAM port drive
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (state == STORE) begin
      mem_a    = addr + {29'd0, k};
      mem_dout = wdata[{k[1:0], 3'b000} +: 8];
      mem_wr   = rdy && !io_stall;
    end else if (reading) begin
      // While frozen, re-present the address of the byte still awaiting capture
      // so the RAM's one-cycle-late output is the right byte on the resume edge.
      if (rdy && (k != nbytes)) begin
        mem_a = addr + {29'd0, k};
      end else if (!rdy && (k != 3'd0)) begin
        mem_a = addr + {29'd0, k} - 32'd1;
      end
    end
  end

  // Arbitration, byte serialisation and result delivery
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      k           <= '0;
      nbytes      <= '0;
      addr        <= '0;
      wdata       <= '0;
      acc         <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      lsb_rdata   <= '0;
      lsb_done    <= 1'b0;
    end else if (rdy) begin
      instr_valid <= 1'b0;
      lsb_done    <= 1'b0;
      case (state)
        IDLE: begin
          k   <= '0;
          acc <= '0;
          if (lsb_req) begin
            state  <= lsb_wr ? STORE : LOAD;
            addr   <= lsb_addr;
            wdata  <= lsb_wdata;
            nbytes <= len_to_bytes(lsb_len);
          end else if (fetch_req) begin
            state  <= FETCH;
            addr   <= fetch_pc;
            nbytes <= 3'd4;
          end
        end
        FETCH, LOAD: begin
          if (clear) begin
            state <= IDLE;
          end else if (k == nbytes) begin
            state <= IDLE;
            if (state == FETCH) begin
              instr       <= acc_nx;
              instr_valid <= 1'b1;
            end else begin
              lsb_rdata <= acc_nx;
              lsb_done  <= 1'b1;
            end
          end else begin
            k <= k + 3'd1;
            if (k != 3'd0) acc <= acc_nx;
          end
        end
        STORE: begin
          if (!io_stall) begin
            if (k == nbytes - 3'd1) begin
              state    <= IDLE;
              lsb_done <= 1'b1;
            end else begin
              k <= k + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
